// File: rtl/axis_downsizer_tlast_if.sv
// AXI4-Stream link bundle (data, last, valid/ready) shared by the wide input
// and narrow output sides of the downsizer.
interface axis_downsizer_tlast_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_downsizer_tlast.sv
// AXI4-Stream width downconverter: splits each wide beat into a runtime-chosen
// number of narrow words, LSB- or MSB-first, and forwards tlast on the final word.
module axis_downsizer_tlast #(
    parameter int S_AXIS_TDATA_WIDTH = 128,
    parameter int M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [15:0]            cfg_data,
    axis_downsizer_tlast_if.slave  s_axis,
    axis_downsizer_tlast_if.master m_axis
);
    localparam int RATIO      = (S_AXIS_TDATA_WIDTH / M_AXIS_TDATA_WIDTH < 1) ? 1 :
                                (S_AXIS_TDATA_WIDTH / M_AXIS_TDATA_WIDTH);
    localparam int CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int NWORDS     = 2 ** CNTR_WIDTH;
    localparam logic [CNTR_WIDTH-1:0] MAX_IDX = CNTR_WIDTH'(RATIO - 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                      state_reg, state_next;
    logic [S_AXIS_TDATA_WIDTH-1:0] data_reg;
    logic                        last_reg, last_next;
    logic [CNTR_WIDTH-1:0]       idx_reg, idx_next;
    logic [CNTR_WIDTH-1:0]       end_idx_reg, end_idx_next;
    logic                        dir_reg, dir_next;

    logic                        busy;
    logic                        at_end;
    logic                        out_fire;
    logic                        accept;
    logic [CNTR_WIDTH-1:0]       cfg_cnt;
    logic [CNTR_WIDTH-1:0]       last_word;
    logic                        unused_cfg_bits;

    logic [M_AXIS_TDATA_WIDTH-1:0] word_arr [NWORDS];

    // Pad the word table to a power of two so idx never addresses past the end.
    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_words
            if (gi < RATIO) begin : g_used
                assign word_arr[gi] = data_reg[gi*M_AXIS_TDATA_WIDTH +: M_AXIS_TDATA_WIDTH];
            end else begin : g_pad
                assign word_arr[gi] = '0;
            end
        end
    endgenerate

    assign unused_cfg_bits = ^cfg_data;
    assign cfg_cnt   = cfg_data[CNTR_WIDTH-1:0];
    assign last_word = (cfg_cnt > MAX_IDX) ? MAX_IDX : cfg_cnt;

    assign busy     = (state_reg == ST_BUSY);
    assign at_end   = (idx_reg == end_idx_reg);
    assign out_fire = busy & m_axis.tready;

    // Combinational ready lets the next beat load on the same edge the last word leaves.
    assign s_axis.tready = ~areset & (~busy | (out_fire & at_end));
    assign accept        = s_axis.tvalid & s_axis.tready;

    assign m_axis.tvalid = busy;
    assign m_axis.tdata  = word_arr[idx_reg];
    assign m_axis.tlast  = busy & last_reg & at_end;

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        end_idx_next = end_idx_reg;
        last_next    = last_reg;
        dir_next     = dir_reg;

        if (out_fire && !at_end) begin
            idx_next = dir_reg ? (idx_reg - 1'b1) : (idx_reg + 1'b1);
        end

        if (accept) begin
            state_next = ST_BUSY;
            last_next  = s_axis.tlast;
            dir_next   = cfg_data[15];
            if (cfg_data[15]) begin
                idx_next     = last_word;
                end_idx_next = '0;
            end else begin
                idx_next     = '0;
                end_idx_next = last_word;
            end
        end else if (out_fire && at_end) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            end_idx_reg <= '0;
            last_reg    <= 1'b0;
            dir_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            end_idx_reg <= end_idx_next;
            last_reg    <= last_next;
            dir_reg     <= dir_next;
        end
    end

    // Payload needs no reset: it is only observed while busy.
    always_ff @(posedge aclk) begin
        if (accept) begin
            data_reg <= s_axis.tdata;
        end
    end
endmodule

// File: tb/tb_axis_downsizer_tlast.sv
// Bench for axis_downsizer_tlast: a 128->32 instance and a 96->32 instance,
// driven with directed beats and checked by a queue-based output scoreboard.
module tb_axis_downsizer_tlast;
    logic        clk;
    logic        areset;
    logic [15:0] cfg_a;
    logic [15:0] cfg_b;
    logic        rand_en;

    int compared;
    int mismatched;
    int xfer_a;

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];

    logic        hold_a, hold_b;
    logic [32:0] hold_val_a, hold_val_b;

    axis_downsizer_tlast_if #(.DATA_WIDTH(128)) sa ();
    axis_downsizer_tlast_if #(.DATA_WIDTH(32))  ma ();
    axis_downsizer_tlast_if #(.DATA_WIDTH(96))  sb ();
    axis_downsizer_tlast_if #(.DATA_WIDTH(32))  mb ();

    axis_downsizer_tlast #(.S_AXIS_TDATA_WIDTH(128), .M_AXIS_TDATA_WIDTH(32)) dut_a (
        .aclk(clk), .areset(areset), .cfg_data(cfg_a), .s_axis(sa), .m_axis(ma));

    axis_downsizer_tlast #(.S_AXIS_TDATA_WIDTH(96), .M_AXIS_TDATA_WIDTH(32)) dut_b (
        .aclk(clk), .areset(areset), .cfg_data(cfg_b), .s_axis(sb), .m_axis(mb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model for the 128->32 instance (RATIO 4).
    task automatic push_model_a(input logic [127:0] d, input logic l, input logic [15:0] c);
        int n;
        int k;
        n = ((c[1:0] > 2'd3) ? 3 : int'(c[1:0])) + 1;
        for (int j = 0; j < n; j++) begin
            k = c[15] ? (n - 1 - j) : j;
            exp_a.push_back({l && (j == n - 1), d[k*32 +: 32]});
        end
    endtask

    task automatic send_a(input logic [127:0] d, input logic l, input logic [15:0] c);
        int  n;
        bit  acc;
        sa.tdata = d; sa.tlast = l; sa.tvalid = 1'b1; cfg_a = c;
        n = 0; acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (sa.tready) acc = 1;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            compared++; mismatched++;
            $display("FAIL accept_a: got no accept, required accept within 200 cycles");
        end
    endtask

    task automatic send_b(input logic [95:0] d, input logic l, input logic [15:0] c);
        int  n;
        bit  acc;
        sb.tdata = d; sb.tlast = l; sb.tvalid = 1'b1; cfg_b = c;
        n = 0; acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (sb.tready) acc = 1;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            compared++; mismatched++;
            $display("FAIL accept_b: got no accept, required accept within 200 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) begin
            compared++; mismatched++;
            $display("FAIL drain: got %0d/%0d words pending, required 0", exp_a.size(), exp_b.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Random backpressure on the narrow side of instance A.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_en) ma.tready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor: pops on every output transfer, checks stability on stalls.
    always @(negedge clk) begin
        if (areset) begin
            hold_a = 1'b0;
            hold_b = 1'b0;
        end else begin
            if (hold_a) begin
                compared++;
                if (!(ma.tvalid && {ma.tlast, ma.tdata} == hold_val_a)) begin
                    mismatched++;
                    $display("FAIL stall_a: got v=%b %h, required v=1 %h", ma.tvalid, {ma.tlast, ma.tdata}, hold_val_a);
                end
            end
            if (hold_b) begin
                compared++;
                if (!(mb.tvalid && {mb.tlast, mb.tdata} == hold_val_b)) begin
                    mismatched++;
                    $display("FAIL stall_b: got v=%b %h, required v=1 %h", mb.tvalid, {mb.tlast, mb.tdata}, hold_val_b);
                end
            end
            if (ma.tvalid && ma.tready) begin
                xfer_a++;
                compared++;
                if (exp_a.size() == 0) begin
                    mismatched++;
                    $display("FAIL word_a: got last=%b %h, required no word", ma.tlast, ma.tdata);
                end else begin
                    logic [32:0] e;
                    e = exp_a.pop_front();
                    if ({ma.tlast, ma.tdata} !== e) begin
                        mismatched++;
                        $display("FAIL word_a: got last=%b %h, required last=%b %h", ma.tlast, ma.tdata, e[32], e[31:0]);
                    end else begin
                        $display("[A] word %h last %b", ma.tdata, ma.tlast);
                    end
                end
            end
            if (mb.tvalid && mb.tready) begin
                compared++;
                if (exp_b.size() == 0) begin
                    mismatched++;
                    $display("FAIL word_b: got last=%b %h, required no word", mb.tlast, mb.tdata);
                end else begin
                    logic [32:0] e;
                    e = exp_b.pop_front();
                    if ({mb.tlast, mb.tdata} !== e) begin
                        mismatched++;
                        $display("FAIL word_b: got last=%b %h, required last=%b %h", mb.tlast, mb.tdata, e[32], e[31:0]);
                    end else begin
                        $display("[B] word %h last %b", mb.tdata, mb.tlast);
                    end
                end
            end
            hold_a = ma.tvalid && !ma.tready;
            hold_val_a = {ma.tlast, ma.tdata};
            hold_b = mb.tvalid && !mb.tready;
            hold_val_b = {mb.tlast, mb.tdata};
        end
    end

    initial begin
        logic [15:0]  cfg_tbl [4];
        logic [127:0] d;
        int           c0;

        compared = 0; mismatched = 0; xfer_a = 0;
        hold_a = 0; hold_b = 0; hold_val_a = '0; hold_val_b = '0;
        rand_en = 1'b0;
        areset = 1'b1;
        cfg_a = '0; cfg_b = '0;
        sa.tdata = '0; sa.tlast = 0; sa.tvalid = 0; ma.tready = 1'b1;
        sb.tdata = '0; sb.tlast = 0; sb.tvalid = 0; mb.tready = 1'b1;
        cfg_tbl[0] = 16'h0003; cfg_tbl[1] = 16'h0001; cfg_tbl[2] = 16'h8003; cfg_tbl[3] = 16'h8002;

        // Reset state
        #3;
        check("rst_m_tvalid_a", 64'(ma.tvalid), 64'd0);
        check("rst_m_tlast_a",  64'(ma.tlast),  64'd0);
        check("rst_s_tready_a", 64'(sa.tready), 64'd0);
        check("rst_m_tvalid_b", 64'(mb.tvalid), 64'd0);
        check("rst_s_tready_b", 64'(sb.tready), 64'd0);
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        #1 check("idle_s_tready_a", 64'(sa.tready), 64'd1);

        // LSB-first, 4 words, tlast on the final word, ready only on word 4
        exp_a.push_back({1'b0, 32'h11111111});
        exp_a.push_back({1'b0, 32'h22222222});
        exp_a.push_back({1'b0, 32'h33333333});
        exp_a.push_back({1'b1, 32'h44444444});
        send_a(128'h44444444_33333333_22222222_11111111, 1'b1, 16'h0003);
        sa.tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s_tready_pulse", 64'(sa.tready), (i == 3) ? 64'd1 : 64'd0);
        end
        drain();

        // MSB-first, N=2: upper words never appear
        exp_a.push_back({1'b0, 32'h22222222});
        exp_a.push_back({1'b1, 32'h11111111});
        send_a(128'h44444444_33333333_22222222_11111111, 1'b1, 16'h8001);
        sa.tvalid = 1'b0;
        drain();

        // Three back-to-back beats: 12 words in 12 consecutive cycles
        c0 = xfer_a;
        for (int b = 0; b < 3; b++) begin
            d = {32'(b*4 + 4), 32'(b*4 + 3), 32'(b*4 + 2), 32'(b*4 + 1)};
            push_model_a(d, (b == 2), 16'h0003);
            send_a(d, (b == 2), 16'h0003);
        end
        sa.tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("b2b_no_gap", 64'(xfer_a - c0), 64'd12);
        drain();

        // 20 beats with random output backpressure and mixed count/order
        rand_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int w = 0; w < 4; w++) d[w*32 +: 32] = 32'hA5000000 | 32'(i << 8) | 32'(w + 1);
            push_model_a(d, (i % 3 == 2), cfg_tbl[i % 4]);
            send_a(d, (i % 3 == 2), cfg_tbl[i % 4]);
        end
        sa.tvalid = 1'b0;
        drain();
        rand_en = 1'b0;
        ma.tready = 1'b1;

        // 96->32: count clamps to 3, cfg change mid-beat ignored, then 1 word
        exp_b.push_back({1'b0, 32'hAAAAAAAA});
        exp_b.push_back({1'b0, 32'hBBBBBBBB});
        exp_b.push_back({1'b1, 32'hCCCCCCCC});
        send_b(96'hCCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1, 16'h0003);
        exp_b.push_back({1'b0, 32'h11111111});
        exp_b.push_back({1'b0, 32'h22222222});
        exp_b.push_back({1'b0, 32'h33333333});
        send_b(96'h33333333_22222222_11111111, 1'b0, 16'h0002);
        cfg_b = 16'h0000;
        sb.tvalid = 1'b0;
        @(posedge clk); #1;
        exp_b.push_back({1'b1, 32'h44444444});
        send_b(96'h66666666_55555555_44444444, 1'b1, 16'h0000);
        exp_b.push_back({1'b0, 32'hCCCCCCCC});
        exp_b.push_back({1'b0, 32'hBBBBBBBB});
        exp_b.push_back({1'b0, 32'hAAAAAAAA});
        send_b(96'hCCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0, 16'h8003);
        sb.tvalid = 1'b0;
        drain();

        // Asynchronous reset while word 2 of a 4-word beat is presented
        exp_a.push_back({1'b0, 32'h11111111});
        exp_a.push_back({1'b0, 32'h22222222});
        exp_a.push_back({1'b0, 32'h33333333});
        exp_a.push_back({1'b1, 32'h44444444});
        send_a(128'h44444444_33333333_22222222_11111111, 1'b1, 16'h0003);
        sa.tvalid = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_word2", 64'(ma.tdata), 64'h22222222);
        areset = 1'b1;
        #1;
        check("async_rst_tvalid", 64'(ma.tvalid), 64'd0);
        check("async_rst_tlast",  64'(ma.tlast),  64'd0);
        check("async_rst_tready", 64'(sa.tready), 64'd0);
        exp_a.delete();
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        exp_a.push_back({1'b0, 32'hD1D1D1D1});
        exp_a.push_back({1'b0, 32'hD2D2D2D2});
        exp_a.push_back({1'b0, 32'hD3D3D3D3});
        exp_a.push_back({1'b0, 32'hD4D4D4D4});
        send_a(128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 1'b0, 16'h0003);
        sa.tvalid = 1'b0;
        drain();
        check("post_idle_tvalid_a", 64'(ma.tvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
